// File: rtl/load_store_unit.sv
// Memory-stage sequencer: checks alignment, issues one dmem request per op and waits for the response.
// Latency: store 2 cycles, load 3+ cycles, fault 1 cycle; stalls the pipeline via o_busy and waits on gnt/rvalid.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [2:0]  o_funct3,
    output logic [1:0]  o_byte_offset,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_dmem_req,
    input  logic        i_dmem_gnt,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          accept;
    logic          fault;
    logic          tmo_hit;
    logic [3:0]    st_mask;
    logic [31:0]   st_wdata;

    assign accept  = i_valid & (i_ren | i_wen);
    assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

    // Gated by reset so the stall releases the moment reset asserts, even with i_valid held high.
    assign o_busy = i_rst_n & (((state == IDLE) & accept) | (state == REQ) | (state == WAIT));

    always_comb begin
        fault = 1'b0;
        if ((i_funct3[1:0] == 2'b01) && i_addr[0])
            fault = 1'b1;
        if ((i_funct3 == 3'b010) && (i_addr[1:0] != 2'b00))
            fault = 1'b1;
        if (i_wen) begin
            if (!(i_funct3 inside {3'b000, 3'b001, 3'b010}))
                fault = 1'b1;
        end else if (i_funct3 inside {3'b011, 3'b110, 3'b111}) begin
            fault = 1'b1;
        end
    end

    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << i_addr[1:0];
                st_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                st_mask  = 4'b1111;
                st_wdata = i_wdata;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            o_done        <= 1'b0;
            o_rdata       <= '0;
            o_funct3      <= '0;
            o_byte_offset <= '0;
            o_misaligned  <= 1'b0;
            o_bus_err     <= 1'b0;
            o_dmem_req    <= 1'b0;
            o_dmem_addr   <= '0;
            o_dmem_wen    <= 1'b0;
            o_dmem_mask   <= '0;
            o_dmem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tmo_cnt       <= '0;
                        o_funct3      <= i_funct3;
                        o_byte_offset <= i_addr[1:0];
                        o_dmem_addr   <= {i_addr[31:2], 2'b00};
                        o_dmem_wen    <= i_wen;
                        o_dmem_mask   <= i_wen ? st_mask : 4'b1111;
                        o_dmem_wdata  <= st_wdata;
                        if (fault) begin
                            state        <= DONE;
                            o_done       <= 1'b1;
                            o_misaligned <= 1'b1;
                        end else begin
                            state      <= REQ;
                            o_dmem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (i_dmem_gnt) begin
                        o_dmem_req <= 1'b0;
                        if (o_dmem_wen) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tmo_hit) begin
                        o_dmem_req <= 1'b0;
                        state      <= DONE;
                        o_done     <= 1'b1;
                        o_bus_err  <= 1'b1;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (i_dmem_rvalid) begin
                        o_rdata <= i_dmem_rdata;
                        state   <= DONE;
                        o_done  <= 1'b1;
                    end else if (tmo_hit) begin
                        state     <= DONE;
                        o_done    <= 1'b1;
                        o_bus_err <= 1'b1;
                    end
                end
                default: begin
                    // DONE: the pipeline advances past this op now, so i_valid is not sampled.
                    state        <= IDLE;
                    o_done       <= 1'b0;
                    o_misaligned <= 1'b0;
                    o_bus_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, valid2, ren, wen, gnt, rvalid;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;

    logic        busy, done, mis, berr, req, dwen;
    logic [31:0] rd_o, daddr, dwdata;
    logic [2:0]  f3_o;
    logic [1:0]  off_o;
    logic [3:0]  mask;

    logic        busy2, done2, mis2, berr2, req2, dwen2;
    logic [31:0] rd_o2, daddr2, dwdata2;
    logic [2:0]  f3_o2;
    logic [1:0]  off_o2;
    logic [3:0]  mask2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        mis;
        logic        berr;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ren(ren), .i_wen(wen),
        .i_funct3(f3), .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done),
        .o_rdata(rd_o), .o_funct3(f3_o), .o_byte_offset(off_o), .o_misaligned(mis),
        .o_bus_err(berr), .o_dmem_req(req), .i_dmem_gnt(gnt), .o_dmem_addr(daddr),
        .o_dmem_wen(dwen), .o_dmem_mask(mask), .o_dmem_wdata(dwdata),
        .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata)
    );

    load_store_unit #(.TIMEOUT(4)) dut_tmo (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .i_ren(ren), .i_wen(wen),
        .i_funct3(f3), .i_addr(addr), .i_wdata(wdata), .o_busy(busy2), .o_done(done2),
        .o_rdata(rd_o2), .o_funct3(f3_o2), .o_byte_offset(off_o2), .o_misaligned(mis2),
        .o_bus_err(berr2), .o_dmem_req(req2), .i_dmem_gnt(gnt), .o_dmem_addr(daddr2),
        .o_dmem_wen(dwen2), .o_dmem_mask(mask2), .o_dmem_wdata(dwdata2),
        .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_op(input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d);
        ren   = r;
        wen   = w;
        f3    = f;
        addr  = a;
        wdata = d;
    endtask

    task automatic push(input logic m, input logic b, input logic [2:0] f, input logic [1:0] o,
                        input logic c, input logic [31:0] d);
        exp_t e;
        e.mis    = m;
        e.berr   = b;
        e.f3     = f;
        e.off    = o;
        e.chk_rd = c;
        e.rd     = d;
        sbq.push_back(e);
    endtask

    task automatic score(input string who, input logic m, input logic b, input logic [2:0] f,
                         input logic [1:0] o, input logic [31:0] d);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({who, "_spurious_done"}, 32'h1, 32'h0);
        end else begin
            e = sbq.pop_front();
            chk({who, "_misaligned"}, 32'(m), 32'(e.mis));
            chk({who, "_bus_err"}, 32'(b), 32'(e.berr));
            chk({who, "_funct3"}, 32'(f), 32'(e.f3));
            chk({who, "_offset"}, 32'(o), 32'(e.off));
            if (e.chk_rd)
                chk({who, "_rdata"}, d, e.rd);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1)
            score("main", mis, berr, f3_o, off_o, rd_o);
        if (rst_n === 1'b1 && done2 === 1'b1)
            score("tmo", mis2, berr2, f3_o2, off_o2, rd_o2);
    end

    logic       fr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       fw [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] ff [6] = '{3'b001, 3'b010, 3'b011, 3'b111, 3'b101, 3'b110};
    logic [31:0] fa [6] = '{32'h101, 32'h102, 32'h0, 32'h4, 32'h103, 32'h8};

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        valid2 = 1'b0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Reset state
        tick(); tick(); mid();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_rdata", rd_o, 32'h0);
        chk("rst_mask", 32'(mask), 32'h0);
        chk("rst_flags", 32'({mis, berr}), 32'h0);
        tick();
        rst_n = 1'b1;

        // LW 0x100, gnt c1, rvalid c2 -> done c3
        tick(); valid = 1'b1; set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        push(1'b0, 1'b0, 3'b010, 2'd0, 1'b1, 32'hDEADBEEF);
        mid(); chk("lw_c0_busy", 32'(busy), 32'h1); chk("lw_c0_req", 32'(req), 32'h0);
        tick(); gnt = 1'b1;
        mid(); chk("lw_c1_req", 32'(req), 32'h1); chk("lw_c1_addr", daddr, 32'h100);
        chk("lw_c1_wen", 32'(dwen), 32'h0); chk("lw_c1_mask", 32'(mask), 32'hF);
        chk("lw_c1_busy", 32'(busy), 32'h1);
        tick(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
        mid(); chk("lw_c2_busy", 32'(busy), 32'h1); chk("lw_c2_req", 32'(req), 32'h0);
        chk("lw_c2_done", 32'(done), 32'h0);
        tick(); rvalid = 1'b0;
        mid(); chk("lw_c3_done", 32'(done), 32'h1); chk("lw_c3_busy", 32'(busy), 32'h0);
        tick(); valid = 1'b0;
        mid(); chk("lw_c4_done", 32'(done), 32'h0); chk("lw_c4_no_reaccept", 32'(req), 32'h0);

        // SB 0x203 -> lane 3, replicated byte, done c2
        tick(); valid = 1'b1; set_op(1'b0, 1'b1, 3'b000, 32'h203, 32'hA5);
        push(1'b0, 1'b0, 3'b000, 2'd3, 1'b0, 32'h0);
        mid(); chk("sb_c0_busy", 32'(busy), 32'h1);
        tick(); gnt = 1'b1;
        mid(); chk("sb_req", 32'(req), 32'h1); chk("sb_mask", 32'(mask), 32'h8);
        chk("sb_addr", daddr, 32'h200); chk("sb_wdata", dwdata, 32'hA5A5A5A5);
        chk("sb_wen", 32'(dwen), 32'h1);
        tick(); gnt = 1'b0; valid = 1'b0;
        mid(); chk("sb_c2_done", 32'(done), 32'h1); chk("rdata_hold", rd_o, 32'hDEADBEEF);
        tick();

        // ren and wen both set: SH at offset 2 wins as a store
        tick(); valid = 1'b1; set_op(1'b1, 1'b1, 3'b001, 32'h6, 32'h00001234);
        push(1'b0, 1'b0, 3'b001, 2'd2, 1'b0, 32'h0);
        tick(); gnt = 1'b1;
        mid(); chk("sh_mask", 32'(mask), 32'hC); chk("sh_addr", daddr, 32'h4);
        chk("sh_wdata", dwdata, 32'h12341234); chk("sh_wen", 32'(dwen), 32'h1);
        tick(); gnt = 1'b0; valid = 1'b0;
        mid(); chk("sh_done", 32'(done), 32'h1);
        tick();

        // Fault table: done the cycle after accept, no request ever
        for (int k = 0; k < 6; k++) begin
            tick(); valid = 1'b1; set_op(fr[k], fw[k], ff[k], fa[k], 32'h0);
            push(1'b1, 1'b0, ff[k], fa[k][1:0], 1'b0, 32'h0);
            mid(); chk("flt_c0_busy", 32'(busy), 32'h1); chk("flt_c0_req", 32'(req), 32'h0);
            tick(); valid = 1'b0;
            mid(); chk("flt_c1_done", 32'(done), 32'h1); chk("flt_c1_mis", 32'(mis), 32'h1);
            chk("flt_c1_req", 32'(req), 32'h0);
        end
        tick();
        mid(); chk("flt_flag_clear", 32'(mis), 32'h0);

        // No enable set: pass-through without stall
        tick(); valid = 1'b1; set_op(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        mid(); chk("nop_busy", 32'(busy), 32'h0);
        tick(); valid = 1'b0;
        mid(); chk("nop_req", 32'(req), 32'h0); chk("nop_done", 32'(done), 32'h0);

        // LBU 0x302: gnt held off 3 cycles, stray rvalid in REQ, real rvalid 4 cycles after gnt
        tick(); valid = 1'b1; set_op(1'b1, 1'b0, 3'b100, 32'h302, 32'h0);
        push(1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            tick(); gnt = 1'b0; rvalid = (i == 1); rdata = 32'hBAD0BAD0;
            mid(); chk("lbu_hold_req", 32'(req), 32'h1); chk("lbu_hold_addr", daddr, 32'h300);
            chk("lbu_hold_mask", 32'(mask), 32'hF);
        end
        tick(); rvalid = 1'b0; gnt = 1'b1;
        mid(); chk("lbu_gnt_req", 32'(req), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); gnt = 1'b0;
            mid(); chk("lbu_wait_busy", 32'(busy), 32'h1); chk("lbu_wait_req", 32'(req), 32'h0);
            chk("lbu_wait_done", 32'(done), 32'h0);
        end
        tick(); rvalid = 1'b1; rdata = 32'h11223344;
        tick(); rvalid = 1'b0; valid = 1'b0;
        mid(); chk("lbu_done", 32'(done), 32'h1);
        tick();

        // Reset during WAIT drops everything at once
        tick(); valid = 1'b1; set_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        tick(); gnt = 1'b1;
        tick(); gnt = 1'b0;
        mid(); chk("arst_pre_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("arst_req", 32'(req), 32'h0); chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0); chk("arst_rdata", rd_o, 32'h0);
        tick(); valid = 1'b0;
        tick(); rst_n = 1'b1;
        tick(); valid = 1'b1; set_op(1'b0, 1'b1, 3'b010, 32'h44, 32'hCAFEF00D);
        push(1'b0, 1'b0, 3'b010, 2'd0, 1'b0, 32'h0);
        tick(); gnt = 1'b1;
        mid(); chk("post_sw_req", 32'(req), 32'h1); chk("post_sw_wdata", dwdata, 32'hCAFEF00D);
        chk("post_sw_mask", 32'(mask), 32'hF);
        tick(); gnt = 1'b0; valid = 1'b0;
        mid(); chk("post_sw_done", 32'(done), 32'h1);
        tick();

        // TIMEOUT=4 instance: rvalid never arrives
        tick(); valid2 = 1'b1; set_op(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        push(1'b0, 1'b1, 3'b010, 2'd0, 1'b0, 32'h0);
        tick(); gnt = 1'b1;
        mid(); chk("tmo_a_req", 32'(req2), 32'h1);
        tick(); gnt = 1'b0;
        tick(); tick();
        mid(); chk("tmo_a_c4_done", 32'(done2), 32'h0); chk("tmo_a_c4_busy", 32'(busy2), 32'h1);
        tick(); valid2 = 1'b0;
        mid(); chk("tmo_a_c5_done", 32'(done2), 32'h1); chk("tmo_a_berr", 32'(berr2), 32'h1);
        tick();
        mid(); chk("tmo_a_berr_clear", 32'(berr2), 32'h0);

        // gnt never arrives: request dropped on abort
        tick(); valid2 = 1'b1; set_op(1'b0, 1'b1, 3'b010, 32'h84, 32'h1);
        push(1'b0, 1'b1, 3'b010, 2'd0, 1'b0, 32'h0);
        tick(); tick(); tick(); tick();
        mid(); chk("tmo_b_c4_req", 32'(req2), 32'h1);
        tick(); valid2 = 1'b0;
        mid(); chk("tmo_b_done", 32'(done2), 32'h1); chk("tmo_b_req_drop", 32'(req2), 32'h0);
        tick();

        // rvalid in the timeout cycle wins
        tick(); valid2 = 1'b1; set_op(1'b1, 1'b0, 3'b010, 32'h88, 32'h0);
        push(1'b0, 1'b0, 3'b010, 2'd0, 1'b1, 32'h5A5A0001);
        tick(); gnt = 1'b1;
        tick(); gnt = 1'b0;
        tick();
        tick(); rvalid = 1'b1; rdata = 32'h5A5A0001;
        tick(); rvalid = 1'b0; valid2 = 1'b0;
        mid(); chk("tmo_c_done", 32'(done2), 32'h1); chk("tmo_c_berr", 32'(berr2), 32'h0);
        tick(); tick();

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
